// File: rtl/gpr_csr_file.sv
// GPR file with INIT clear sequence plus machine-mode CSRs (mstatus/mtvec/mepc/mcause).
// Define REGFILE_BYPASS_EN to forward accepted same-cycle writes onto the read ports.
module gpr_csr_file #(
    parameter int XLEN     = 32,
    parameter int NR_GPR   = 16,
    parameter int NR_RPORT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NR_RPORT*5-1:0]    rs_addr,
    output logic [NR_RPORT*XLEN-1:0] rs_data,
    input  logic                     rd_wen,
    input  logic [4:0]               rd_addr,
    input  logic [XLEN-1:0]          rd_wdata,
    input  logic [11:0]              csr_raddr,
    output logic [XLEN-1:0]          csr_rdata,
    input  logic                     csr_wen,
    input  logic [11:0]              csr_waddr,
    input  logic [XLEN-1:0]          csr_wdata,
    input  logic                     trap_valid,
    input  logic [XLEN-1:0]          trap_pc,
    input  logic [XLEN-1:0]          trap_cause,
    input  logic                     mret_valid,
    output logic [XLEN-1:0]          trap_vector,
    output logic [XLEN-1:0]          mret_pc,
    output logic                     ready,
    output logic                     csr_illegal
);
    localparam int IW = $clog2(NR_GPR);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t        state, state_nx;
    logic [IW-1:0] clr_idx;
    logic          run;

    logic [XLEN-1:0] gpr [NR_GPR];
    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mepc, mcause;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == S_INIT && clr_idx == IW'(NR_GPR - 1)) state_nx = S_RUN;
    end

    always_comb begin
        run = (state == S_RUN);
    end

    assign ready = run;

    always_ff @(posedge clk) begin
        if (rst)                 clr_idx <= '0;
        else if (state == S_INIT) clr_idx <= clr_idx + 1'b1;
    end

    // 6-bit compare so NR_GPR=32 does not wrap to zero
    logic gpr_we;
    assign gpr_we = run && rd_wen && (rd_addr != 5'd0) && ({1'b0, rd_addr} < 6'(NR_GPR));

    always_ff @(posedge clk) begin
        if (state == S_INIT) gpr[clr_idx] <= '0;
        else if (gpr_we)     gpr[rd_addr[IW-1:0]] <= rd_wdata;
    end

    for (genvar i = 0; i < NR_RPORT; i++) begin : g_rport
        logic [4:0]      a;
        logic [XLEN-1:0] val;
        assign a = rs_addr[5*i +: 5];
        always_comb begin
            val = '0;
            if (run && a != 5'd0 && {1'b0, a} < 6'(NR_GPR)) val = gpr[a[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
            if (gpr_we && rd_addr == a) val = rd_wdata;
`endif
        end
        assign rs_data[XLEN*i +: XLEN] = val;
    end

    // Per-register arbitration: trap beats mret beats csr_wen, only where they collide
    logic trap_go, mret_go, csr_go;
    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;
    assign trap_go    = run && trap_valid;
    assign mret_go    = run && mret_valid && !trap_valid;
    assign csr_go     = run && csr_wen;
    assign wr_mstatus = csr_go && csr_waddr == A_MSTATUS && !trap_valid && !mret_valid;
    assign wr_mtvec   = csr_go && csr_waddr == A_MTVEC;
    assign wr_mepc    = csr_go && csr_waddr == A_MEPC && !trap_valid;
    assign wr_mcause  = csr_go && csr_waddr == A_MCAUSE && !trap_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= '0;
            mepc   <= '0;
            mcause <= '0;
        end else begin
            if (trap_go) begin
                mepc   <= trap_pc;
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret_go) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mie  <= csr_wdata[3];
                mpie <= csr_wdata[7];
            end
            if (wr_mtvec)  mtvec  <= {csr_wdata[XLEN-1:2], 2'b00};
            if (wr_mepc)   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
            if (wr_mcause) mcause <= csr_wdata;
        end
    end

    function automatic logic [XLEN-1:0] mstatus_val(input logic ie, input logic pie);
        logic [XLEN-1:0] v;
        v        = '0;
        v[12:11] = 2'b11;
        v[7]     = pie;
        v[3]     = ie;
        return v;
    endfunction

    always_comb begin
        csr_rdata   = '0;
        csr_illegal = 1'b0;
        unique case (csr_raddr)
            A_MSTATUS: csr_rdata = mstatus_val(mie, mpie);
            A_MTVEC:   csr_rdata = mtvec;
            A_MEPC:    csr_rdata = mepc;
            A_MCAUSE:  csr_rdata = mcause;
            default:   csr_illegal = 1'b1;
        endcase
`ifdef REGFILE_BYPASS_EN
        if (wr_mstatus && csr_raddr == A_MSTATUS) csr_rdata = mstatus_val(csr_wdata[3], csr_wdata[7]);
        if ((wr_mtvec && csr_raddr == A_MTVEC) || (wr_mepc && csr_raddr == A_MEPC))
            csr_rdata = {csr_wdata[XLEN-1:2], 2'b00};
        if (wr_mcause && csr_raddr == A_MCAUSE) csr_rdata = csr_wdata;
`endif
    end

    assign trap_vector = mtvec;
    assign mret_pc     = mepc;
endmodule

// File: tb/tb_gpr_csr_file.sv
// Randomised + directed bench for gpr_csr_file against a behavioural register/CSR model.
module tb_gpr_csr_file;
    localparam int XLEN = 32, NR_GPR = 16, NR_RPORT = 2;

    logic clk = 1'b0, rst;
    logic [NR_RPORT*5-1:0]    rs_addr;
    logic [NR_RPORT*XLEN-1:0] rs_data;
    logic rd_wen; logic [4:0] rd_addr; logic [XLEN-1:0] rd_wdata;
    logic [11:0] csr_raddr, csr_waddr; logic [XLEN-1:0] csr_rdata, csr_wdata;
    logic csr_wen, trap_valid, mret_valid, ready, csr_illegal;
    logic [XLEN-1:0] trap_pc, trap_cause, trap_vector, mret_pc;

    gpr_csr_file #(.XLEN(XLEN), .NR_GPR(NR_GPR), .NR_RPORT(NR_RPORT)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .trap_valid(trap_valid),
        .trap_pc(trap_pc), .trap_cause(trap_cause), .mret_valid(mret_valid),
        .trap_vector(trap_vector), .mret_pc(mret_pc), .ready(ready),
        .csr_illegal(csr_illegal));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state only, cycles since reset for readiness
    logic [31:0] m_gpr [32];
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    int          m_cnt;

    function automatic bit m_ready();
        return m_cnt >= NR_GPR;
    endfunction

    function automatic logic [31:0] exp_gpr(input logic [4:0] a);
        if (!m_ready() || a == 0 || a >= NR_GPR) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rd_wen && rd_addr == a) return rd_wdata;
`endif
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] a);
`ifdef REGFILE_BYPASS_EN
        if (m_ready() && csr_wen && csr_waddr == a) begin
            if (a == 12'h300 && !trap_valid && !mret_valid)
                return 32'h1800 | (32'(csr_wdata[3]) << 3) | (32'(csr_wdata[7]) << 7);
            if (a == 12'h305) return csr_wdata & ~32'h3;
            if (a == 12'h341 && !trap_valid) return csr_wdata & ~32'h3;
            if (a == 12'h342 && !trap_valid) return csr_wdata;
        end
`endif
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_mie = 1'b0; m_mpie = 1'b0;
            m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
        end else if (!m_ready()) begin
            m_cnt++;
        end else begin
            if (rd_wen && rd_addr != 0 && rd_addr < NR_GPR) m_gpr[rd_addr] = rd_wdata;
            if (csr_wen) begin
                case (csr_waddr)
                    12'h300: if (!trap_valid && !mret_valid) begin
                        m_mie = csr_wdata[3]; m_mpie = csr_wdata[7];
                    end
                    12'h305: m_mtvec = csr_wdata & ~32'h3;
                    12'h341: if (!trap_valid) m_mepc = csr_wdata & ~32'h3;
                    12'h342: if (!trap_valid) m_mcause = csr_wdata;
                    default: ;
                endcase
            end
            if (trap_valid) begin
                m_mepc = trap_pc; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 1'b0;
            end else if (mret_valid) begin
                m_mie = m_mpie; m_mpie = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", {31'b0, ready}, {31'b0, m_ready()});
            for (int p = 0; p < NR_RPORT; p++)
                chk($sformatf("rs_data%0d", p), rs_data[32*p +: 32], exp_gpr(rs_addr[5*p +: 5]));
            chk("csr_rdata", csr_rdata, exp_csr(csr_raddr));
            chk("csr_illegal", {31'b0, csr_illegal},
                {31'b0, !(csr_raddr inside {12'h300, 12'h305, 12'h341, 12'h342})});
            chk("trap_vector", trap_vector, m_mtvec);
            chk("mret_pc", mret_pc, m_mepc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rd_wen = 0; csr_wen = 0; trap_valid = 0; mret_valid = 0;
    endtask

    task automatic wait_ready(input string name);
        int cyc = 0;
        while (!ready && cyc < 100) begin tick(); cyc++; end
        chk(name, cyc, 16);
    endtask

    function automatic logic [11:0] pick_csr();
        case ($urandom_range(0, 4))
            0: return 12'h300;
            1: return 12'h305;
            2: return 12'h341;
            3: return 12'h342;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; rs_addr = '0; rd_addr = '0; rd_wdata = '0; csr_raddr = '0;
        csr_waddr = '0; csr_wdata = '0; trap_pc = '0; trap_cause = '0;
        idle();
        tick(); cmp_en = 1'b1;
        tick(); rst = 0;

        // reset/INIT length, cleared state
        wait_ready("init_len");
        rs_addr = {5'd9, 5'd3}; csr_raddr = 12'h300; #1;
        chk("lit_rs0_zero", rs_data[31:0], 32'h0);
        chk("lit_mstatus_reset", csr_rdata, 32'h0000_1800);

        // GPR writes incl. x0 and out-of-range x20
        rd_wen = 1; rd_addr = 5; rd_wdata = 32'hDEAD_BEEF; tick();
        rd_addr = 0; rd_wdata = 32'h1; tick();
        rd_addr = 20; rd_wdata = 32'h2; tick();
        idle(); rs_addr = {5'd0, 5'd5}; #1;
        chk("lit_x5", rs_data[31:0], 32'hDEAD_BEEF);
        chk("lit_x0", rs_data[63:32], 32'h0);
        rs_addr = {5'd4, 5'd20}; #1;
        chk("lit_x20", rs_data[31:0], 32'h0);
        chk("lit_x4", rs_data[63:32], 32'h0);

        // trap then mret
        csr_wen = 1; csr_waddr = 12'h300; csr_wdata = 32'h8; tick();
        idle(); trap_valid = 1; trap_pc = 32'h8000_0104; trap_cause = 32'd11; tick();
        idle(); csr_raddr = 12'h341; #1; chk("lit_mepc_trap", csr_rdata, 32'h8000_0104);
        csr_raddr = 12'h342; #1; chk("lit_mcause_trap", csr_rdata, 32'd11);
        csr_raddr = 12'h300; #1; chk("lit_mstatus_trap", csr_rdata, 32'h1880);
        mret_valid = 1; tick(); idle(); #1;
        chk("lit_mstatus_mret", csr_rdata, 32'h1888);

        // same-cycle trap + mret + csr writes
        trap_valid = 1; mret_valid = 1; trap_pc = 32'h4000_0010; trap_cause = 32'd2;
        csr_wen = 1; csr_waddr = 12'h341; csr_wdata = 32'h1234; tick();
        csr_waddr = 12'h305; csr_wdata = 32'h8000_0003; csr_raddr = 12'h300; #1;
        chk("lit_mstatus_prio", csr_rdata, 32'h1880);
        tick(); idle(); #1;
        chk("lit_mepc_prio", mret_pc, 32'h4000_0010);
        chk("lit_mtvec_prio", trap_vector, 32'h8000_0000);
        csr_raddr = 12'h342; #1; chk("lit_mcause_prio", csr_rdata, 32'd2);

        // same-cycle write/read of x7; illegal CSR
        rd_wen = 1; rd_addr = 7; rd_wdata = 32'h55; rs_addr = {5'd0, 5'd7}; csr_raddr = 12'h7C0; #1;
`ifdef REGFILE_BYPASS_EN
        chk("lit_x7_bypass", rs_data[31:0], 32'h55);
`else
        chk("lit_x7_old", rs_data[31:0], 32'h0);
`endif
        chk("lit_illegal_data", csr_rdata, 32'h0);
        chk("lit_illegal_flag", {31'b0, csr_illegal}, 32'h1);
        tick(); idle(); #1; chk("lit_x7_new", rs_data[31:0], 32'h55);

        // restart mid-INIT, writes ignored during INIT
        rst = 1; tick(); rst = 0;
        repeat (9) tick();
        rst = 1; tick(); rst = 0;
        rd_wen = 1; rd_addr = 3; rd_wdata = 32'hFF; csr_wen = 1; csr_waddr = 12'h305;
        csr_wdata = 32'h100; trap_valid = 1; trap_pc = 32'h44;
        wait_ready("restart_len");
        idle(); rs_addr = {5'd7, 5'd3}; #1;
        chk("lit_x3_init", rs_data[31:0], 32'h0);
        chk("lit_x7_cleared", rs_data[63:32], 32'h0);
        chk("lit_mtvec_init", trap_vector, 32'h0);
        chk("lit_mepc_init", mret_pc, 32'h0);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst        = ($urandom_range(0, 299) == 0);
            rs_addr    = NR_RPORT*5'($urandom);
            rd_wen     = 1'($urandom);
            rd_addr    = 5'($urandom);
            rd_wdata   = $urandom;
            csr_raddr  = pick_csr();
            csr_wen    = ($urandom_range(0, 2) == 0);
            csr_waddr  = pick_csr();
            csr_wdata  = $urandom;
            trap_valid = ($urandom_range(0, 9) == 0);
            trap_pc    = $urandom & ~32'h3;
            trap_cause = $urandom;
            mret_valid = ($urandom_range(0, 7) == 0);
        end
        tick(); rst = 0; idle(); tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
